// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared single-port RAM connection
// seen by mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_load;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
    output ack0, ack1, rdata, busy, ram_address, ram_data_in, ram_load
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
    input  ack0, ack1, rdata, busy, ram_address, ram_data_in, ram_load
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a level-sensitive single-port RAM.
// Every RAM-facing signal comes straight from a flop so the RAM never sees glitches.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WSETUP, WSTROBE, WHOLD} state_t;

  state_t                state, state_d;
  logic                  last, last_d;
  logic                  port, port_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  load_q, load_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  elig0, elig1, sel;

  // A port whose ack is high this cycle is masked so a still-held request is not served twice.
  assign elig0 = bus.req0 & ~ack0_q;
  assign elig1 = bus.req1 & ~ack1_q;
  assign sel   = (elig0 & elig1) ? ~last : elig1;

  always_comb begin
    state_d = state;
    last_d  = last;
    port_d  = port;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state)
      IDLE: begin
        // The RAM address/data flops double as the transaction register.
        if (elig0 | elig1) begin
          port_d  = sel;
          last_d  = sel;
          addr_d  = sel ? bus.addr1 : bus.addr0;
          wdata_d = sel ? bus.wdata1 : bus.wdata0;
          state_d = (sel ? bus.we1 : bus.we0) ? WSETUP : RD;
        end
      end
      RD: begin
        rdata_d = bus.ram_data_out;
        ack0_d  = ~port;
        ack1_d  = port;
        state_d = IDLE;
      end
      WSETUP: begin
        load_d  = 1'b1;
        state_d = WSTROBE;
      end
      WSTROBE: state_d = WHOLD;
      WHOLD: begin
        ack0_d  = ~port;
        ack1_d  = port;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      port    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_d;
      last    <= last_d;
      port    <= port_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = (state != IDLE);
  assign bus.ram_address = addr_q;
  assign bus.ram_data_in = wdata_q;
  assign bus.ram_load    = load_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a level-sensitive RAM model; cycle 0 is the
// IDLE cycle in which a request is first presented.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   both_acks;
  int   load_cycles;
  logic [31:0] mem [0:4095];

  mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(bus.ram_load or bus.ram_address or bus.ram_data_in)
    if (bus.ram_load) mem[bus.ram_address] = bus.ram_data_in;
  assign bus.ram_data_out = mem[bus.ram_address];

  always @(negedge clk) begin
    if (rst_n && bus.ack0 && bus.ack1) both_acks++;
    if (rst_n && bus.ram_load) load_cycles++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = a; bus.wdata1 = d;
    repeat (4) next();
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    next();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++; if (bus.ram_load !== 1'b0) begin fails++; $display("FAIL reset_load got %b want 0", bus.ram_load); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if ({bus.ack0, bus.ack1} !== 2'b00) begin fails++; $display("FAIL reset_acks got %b want 00", {bus.ack0, bus.ack1}); end
    tests++; if (bus.ram_address !== 12'h000) begin fails++; $display("FAIL reset_addr got %h want 000", bus.ram_address); end
    tests++; if (bus.ram_data_in !== 32'h0) begin fails++; $display("FAIL reset_din got %h want 0", bus.ram_data_in); end
    tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
    next();
    rst_n = 1'b1;
    next();
  endtask

  task automatic test_single_write();
    logic [4:0] exp_load, exp_ack, exp_busy;
    exp_load = 5'b00100; exp_ack = 5'b10000; exp_busy = 5'b01110;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h005; bus.wdata1 = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      tests++; if (bus.ram_load !== exp_load[c]) begin fails++; $display("FAIL wr_load c%0d got %b want %b", c, bus.ram_load, exp_load[c]); end
      tests++; if (bus.ack1 !== exp_ack[c] || bus.ack0 !== 1'b0) begin fails++; $display("FAIL wr_ack c%0d got %b%b want 0%b", c, bus.ack0, bus.ack1, exp_ack[c]); end
      tests++; if (bus.busy !== exp_busy[c]) begin fails++; $display("FAIL wr_busy c%0d got %b want %b", c, bus.busy, exp_busy[c]); end
      if (c >= 1 && c <= 3) begin
        tests++; if (bus.ram_address !== 12'h005 || bus.ram_data_in !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_bus c%0d got %h/%h want 005/deadbeef", c, bus.ram_address, bus.ram_data_in); end
      end
      if (c == 4) begin
        tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL wr_rdata_kept got %h want 0", bus.rdata); end
        bus.req1 = 1'b0; bus.we1 = 1'b0;
      end
      next();
    end
  endtask

  task automatic test_read_back();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h005;
    for (int c = 0; c < 3; c++) begin
      tests++; if (bus.ack0 !== (c == 2)) begin fails++; $display("FAIL rd_ack0 c%0d got %b want %b", c, bus.ack0, (c == 2)); end
      if (c == 2) begin
        tests++; if (bus.rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got %h want deadbeef", bus.rdata); end
        bus.req0 = 1'b0;
      end
      next();
    end
  endtask

  task automatic test_held_req();
    logic [4:0] exp_ack, exp_busy;
    exp_ack = 5'b00100; exp_busy = 5'b00010;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h005;
    for (int c = 0; c < 5; c++) begin
      tests++; if (bus.ack0 !== exp_ack[c]) begin fails++; $display("FAIL held_ack0 c%0d got %b want %b", c, bus.ack0, exp_ack[c]); end
      tests++; if (bus.busy !== exp_busy[c]) begin fails++; $display("FAIL held_busy c%0d got %b want %b", c, bus.busy, exp_busy[c]); end
      if (c == 3) bus.req0 = 1'b0;
      next();
    end
  endtask

  task automatic test_tie();
    logic [8:0] exp_a0, exp_a1;
    exp_a0 = 9'b001000100; exp_a1 = 9'b100010000;
    do_write(12'h010, 32'hAAAA0000);
    do_write(12'h020, 32'hBBBB1111);
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    next();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h010;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'h020;
    for (int c = 0; c < 9; c++) begin
      tests++; if (bus.ack0 !== exp_a0[c] || bus.ack1 !== exp_a1[c]) begin fails++; $display("FAIL tie_acks c%0d got %b%b want %b%b", c, bus.ack0, bus.ack1, exp_a0[c], exp_a1[c]); end
      if (exp_a0[c]) begin
        tests++; if (bus.rdata !== 32'hAAAA0000) begin fails++; $display("FAIL tie_rdata0 c%0d got %h want aaaa0000", c, bus.rdata); end
      end
      if (exp_a1[c]) begin
        tests++; if (bus.rdata !== 32'hBBBB1111) begin fails++; $display("FAIL tie_rdata1 c%0d got %h want bbbb1111", c, bus.rdata); end
      end
      if (c == 8) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      next();
    end
    next();
  endtask

  task automatic test_reset_wstrobe();
    do_write(12'h030, 32'hCAFEF00D);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h030; bus.wdata1 = 32'h12345678;
    next();
    next();
    tests++; if (bus.ram_load !== 1'b1) begin fails++; $display("FAIL rst_pre_load got %b want 1", bus.ram_load); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.ram_load !== 1'b0) begin fails++; $display("FAIL rst_async_load got %b want 0", bus.ram_load); end
    tests++; if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000) begin fails++; $display("FAIL rst_async_state got %b want 000", {bus.ack0, bus.ack1, bus.busy}); end
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    next();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next();
      tests++; if ({bus.ram_load, bus.ack0, bus.ack1} !== 3'b000) begin fails++; $display("FAIL rst_after c%0d got %b want 000", c, {bus.ram_load, bus.ack0, bus.ack1}); end
    end
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h030;
    next();
    next();
    tests++; if (bus.ack0 !== 1'b1) begin fails++; $display("FAIL rst_readback_ack got %b want 1", bus.ack0); end
    tests++; if (bus.rdata !== 32'hCAFEF00D && bus.rdata !== 32'h12345678) begin fails++; $display("FAIL rst_readback_data got %h want cafef00d or 12345678", bus.rdata); end
    bus.req0 = 1'b0;
    next();
  endtask

  task automatic test_boundary();
    do_write(12'h000, 32'h0BADC0DE);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'hFFF; bus.wdata1 = 32'h00000001;
    repeat (4) next();
    tests++; if (bus.ack1 !== 1'b1) begin fails++; $display("FAIL bnd_wr_ack got %b want 1", bus.ack1); end
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    next();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'hFFF;
    next();
    next();
    tests++; if (bus.ack0 !== 1'b1 || bus.rdata !== 32'h00000001) begin fails++; $display("FAIL bnd_rd_fff got ack %b data %h want 1/00000001", bus.ack0, bus.rdata); end
    bus.req0 = 1'b0;
    next();
    bus.req0 = 1'b1; bus.addr0 = 12'h000;
    next();
    next();
    tests++; if (bus.ack0 !== 1'b1 || bus.rdata !== 32'h0BADC0DE) begin fails++; $display("FAIL bnd_rd_000 got ack %b data %h want 1/0badc0de", bus.ack0, bus.rdata); end
    bus.req0 = 1'b0;
    next();
  endtask

  task automatic test_exclusive();
    tests++; if (both_acks !== 0) begin fails++; $display("FAIL excl_acks got %0d want 0", both_acks); end
    tests++; if (load_cycles !== 6) begin fails++; $display("FAIL load_cycles got %0d want 6", load_cycles); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    tests = 0; fails = 0; both_acks = 0; load_cycles = 0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    test_reset();
    test_single_write();
    test_read_back();
    test_held_req();
    test_tie();
    test_reset_wstrobe();
    test_boundary();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, word address width of the shared RAM.
REQ-002 Parameter DATA_WIDTH, default 32, data word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0 / req1  input  1 each  port request (port 0 = instruction fetch, port 1 = data).
REQ-006 we0 / we1  input  1 each  1 = write, 0 = read.
REQ-007 addr0 / addr1  input  ADDR_WIDTH each  word address.
REQ-008 wdata0 / wdata1  input  DATA_WIDTH each  write data.
REQ-009 ack0 / ack1  output  1 each  one-cycle completion pulse.
REQ-010 rdata  output  DATA_WIDTH  read data, shared by both ports, valid while ackN=1 for a read.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 ram_address  output  ADDR_WIDTH  to RAM address.
REQ-013 ram_data_in  output  DATA_WIDTH  to RAM data_in.
REQ-014 ram_load  output  1  to RAM load (level-sensitive write enable).
REQ-015 ram_data_out  input  DATA_WIDTH  from RAM (combinational read).

Function
REQ-016 FSM states: IDLE, RD, WSETUP, WSTROBE, WHOLD.
REQ-017 ram_address, ram_data_in and ram_load shall be driven directly from flops (no combinational path), so the level-sensitive RAM never sees glitches.
REQ-018 IDLE: when an eligible request is present, latch the winning port's addr/we/wdata into a transaction register and go to RD (we=0) or WSETUP (we=1); otherwise remain in IDLE.
REQ-019 Arbitration: round-robin on a 1-bit last-served pointer; when both ports are eligible, grant the port not last served; a single eligible port is granted immediately.
REQ-020 RD: ram_address = latched addr, ram_load = 0; on exit edge capture ram_data_out into rdata, pulse ack of granted port, return to IDLE.
REQ-021 WSETUP: ram_address and ram_data_in = latched values, ram_load = 0 -> WSTROBE.
REQ-022 WSTROBE: ram_load = 1, address/data held -> WHOLD.
REQ-023 WHOLD: ram_load = 0, address/data still held; on exit pulse ack of granted port -> IDLE.
REQ-024 Latency from request sampled in IDLE (cycle 0): read ack in cycle 2, write ack in cycle 4.
REQ-025 Requester shall hold req, we, addr and wdata stable until its ack; arbiter samples them only in IDLE.
REQ-026 In the IDLE cycle coinciding with ackN, reqN is masked (not eligible), preventing double service of a request not yet deasserted; the other port remains eligible.
REQ-027 rdata holds its last captured value until the next read completes; write completions leave rdata unchanged.
REQ-028 ack0 and ack1 shall never be high in the same cycle; ram_load shall be high for exactly one cycle per write.
REQ-029 The pointer updates on grant, not on ack.

Reset
REQ-030 rst_n = 0 shall asynchronously force: state IDLE, ram_load 0, ram_address 0, ram_data_in 0, ack0/ack1 0, rdata 0, busy 0, pointer = port 1 (so port 0 wins the first tie).
REQ-031 Reset mid-transaction (any state) abandons the transaction with no ack; a write reset during WSTROBE shall drop ram_load immediately, with no further RAM modification.

Verification
REQ-032 Single write: req1=1, we1=1, addr1=0x005, wdata1=0xDEADBEEF -> ram_load high only in cycle 2, ack1 in cycle 4, ram_address=0x005 in cycles 1-3.
REQ-033 Read-back: then req0=1, we0=0, addr0=0x005 -> ack0 in cycle 2, rdata=0xDEADBEEF.
REQ-034 Tie after reset: req0 and req1 both reads, held continuously -> grant order 0,1,0,1; acks alternate every 2 cycles; no simultaneous acks.
REQ-035 Held req after ack: req0 kept high one extra cycle past ack0, req1=0 -> no second transaction starts in the ack cycle; busy=0 that cycle.
REQ-036 Reset in WSTROBE: assert rst_n=0 mid-cycle -> ram_load falls without a clock edge, no ack; the subsequent read of that address returns its old value or new value, and ram_load never re-asserts.
REQ-037 Boundary address: write 0xFFF with 0x00000001 then read 0xFFF -> rdata=0x00000001; address 0x000 unaffected.
